calc_key_sequencer: RTL and testbench

- Control FSM for the PS/2 keypad calculator.
- Consumes validated scan-code bytes from the PS/2 frame receiver and filters make/break/extended codes and typematic repeats.
- Sequences operand A entry, operator, operand B entry and '=', then runs a multi-cycle binary-to-BCD conversion of the result.
- Drives BCD digits that the top level maps to hex7..hex4 (operands) and hex1..hex0 plus sign/hundreds (result).

---
 rtl/calc_pkg.sv | 51 +++++
 rtl/calc_bin2bcd.sv | 75 +++++++
 rtl/calc_key_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_calc_key_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the PS/2 keypad calculator.
//   - scan-code constants for the keys the calculator understands
//   - control FSM state encoding
//   - decode_digit(): maps a scan code to {vld, BCD value}
package calc_pkg;

  localparam logic [7:0] SC_0     = 8'h70;
  localparam logic [7:0] SC_1     = 8'h69;
  localparam logic [7:0] SC_2     = 8'h72;
  localparam logic [7:0] SC_3     = 8'h7A;
  localparam logic [7:0] SC_4     = 8'h6B;
  localparam logic [7:0] SC_5     = 8'h73;
  localparam logic [7:0] SC_6     = 8'h74;
  localparam logic [7:0] SC_7     = 8'h6C;
  localparam logic [7:0] SC_8     = 8'h75;
  localparam logic [7:0] SC_9     = 8'h7D;
  localparam logic [7:0] SC_PLUS  = 8'h79;
  localparam logic [7:0] SC_MINUS = 8'h7B;
  localparam logic [7:0] SC_EQ    = 8'h55;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {S_A, S_B, S_CONV, S_SHOW} state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] val;
  } digit_t;

  function automatic digit_t decode_digit(input logic [7:0] code);
    digit_t d;
    d.vld = 1'b1;
    d.val = 4'd0;
    case (code)
      SC_0:    d.val = 4'd0;
      SC_1:    d.val = 4'd1;
      SC_2:    d.val = 4'd2;
      SC_3:    d.val = 4'd3;
      SC_4:    d.val = 4'd4;
      SC_5:    d.val = 4'd5;
      SC_6:    d.val = 4'd6;
      SC_7:    d.val = 4'd7;
      SC_8:    d.val = 4'd8;
      SC_9:    d.val = 4'd9;
      default: d.vld = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// calc_bin2bcd: sequential double-dabble binary-to-BCD converter.
// Ports:
//   clk, rst        clock, synchronous active-high reset (also used as abort)
//   start           one-cycle strobe: load bin
//   bin             binary magnitude to convert
//   done            one-cycle pulse, CONV_ITER+1 cycles after the start cycle
//   hund/tens/ones  BCD result, valid while done is high and until next start
module calc_bin2bcd
  import calc_pkg::*;
#(
  parameter int CONV_ITER = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CONV_ITER-1:0] bin,
  output logic                 done,
  output logic [3:0]           hund,
  output logic [3:0]           tens,
  output logic [3:0]           ones
);

  localparam int               SH_W  = CONV_ITER + 12;
  localparam int               CNT_W = $clog2(CONV_ITER);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CONV_ITER - 1);

  logic [SH_W-1:0]  r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_done;

  // One double-dabble step: bias every BCD digit >= 5 by 3, then shift left.
  function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] sh);
    logic [SH_W-1:0] t;
    t = sh;
    for (int i = 0; i < 3; i++) begin
      if (t[CONV_ITER + 4*i +: 4] >= 4'd5)
        t[CONV_ITER + 4*i +: 4] = t[CONV_ITER + 4*i +: 4] + 4'd3;
    end
    return {t[SH_W-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_run <= 1'b1;
        r_cnt <= '0;
      end else if (r_run) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start)
      r_sh <= {12'd0, bin};
    else if (r_run)
      r_sh <= dabble_step(r_sh);
  end

  assign done = r_done;
  assign hund = r_sh[SH_W-1 -: 4];
  assign tens = r_sh[CONV_ITER + 4 +: 4];
  assign ones = r_sh[CONV_ITER +: 4];

endmodule

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: control FSM of the PS/2 keypad calculator.
// Filters make/break/extended scan codes and typematic repeats, sequences
// operand A, operator, operand B and '=', then converts the result to BCD.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   code_valid, code_byte    validated scan-code byte strobe
//   a_tens/a_ones            operand A BCD digits
//   b_tens/b_ones            operand B BCD digits
//   op_minus                 0 = add, 1 = subtract
//   r_hund/r_tens/r_ones     result magnitude BCD; r_neg sign; r_valid valid
//   busy                     conversion in progress
//   key_err                  one-cycle pulse on an illegal accepted key
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 2,
  parameter int CONV_ITER  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] code_byte,
  output logic [3:0] a_tens,
  output logic [3:0] a_ones,
  output logic [3:0] b_tens,
  output logic [3:0] b_ones,
  output logic       op_minus,
  output logic [3:0] r_hund,
  output logic [3:0] r_tens,
  output logic [3:0] r_ones,
  output logic       r_neg,
  output logic       r_valid,
  output logic       busy,
  output logic       key_err
);

  localparam int               CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAXD  = CNT_W'(MAX_DIGITS);

  state_t           r_state;
  logic             r_ext, r_brk, r_held;
  logic [7:0]       r_held_code;
  logic [3:0]       r_a_tens, r_a_ones, r_b_tens, r_b_ones;
  logic [CNT_W-1:0] r_a_cnt, r_b_cnt;
  logic             r_op_minus;
  logic [3:0]       r_res_hund, r_res_tens, r_res_ones;
  logic             r_res_neg, r_res_valid, r_busy, r_key_err;
  logic             r_conv_start;

  digit_t     w_dig;
  logic       w_press, w_op, w_minus, w_eq, w_esc, w_clear, w_sub_rst;
  logic [6:0] w_a_bin, w_b_bin;
  logic       w_a_lt_b;
  logic [7:0] w_mag;
  logic       w_done;
  logic [3:0] w_bcd_hund, w_bcd_tens, w_bcd_ones;

  // A press is a key code arriving with no pending break/extended prefix and
  // no key currently held; anything else is a release, prefix or repeat.
  assign w_press = code_valid && (code_byte != SC_EXT) && (code_byte != SC_BRK) &&
                   !r_brk && !r_ext && !r_held;
  assign w_dig   = decode_digit(code_byte);
  assign w_minus = (code_byte == SC_MINUS);
  assign w_op    = (code_byte == SC_PLUS) || w_minus;
  assign w_eq    = (code_byte == SC_EQ);
  assign w_esc   = (code_byte == SC_ESC);
  // ESC anywhere, or a digit while a result is shown, restarts entry.
  assign w_clear   = w_press && (w_esc || ((r_state == S_SHOW) && w_dig.vld));
  assign w_sub_rst = reset || (w_press && w_esc);

  assign w_a_bin  = {3'd0, r_a_tens} * 7'd10 + {3'd0, r_a_ones};
  assign w_b_bin  = {3'd0, r_b_tens} * 7'd10 + {3'd0, r_b_ones};
  assign w_a_lt_b = (w_a_bin < w_b_bin);
  assign w_mag    = !r_op_minus ? ({1'b0, w_a_bin} + {1'b0, w_b_bin}) :
                    w_a_lt_b    ? {1'b0, w_b_bin - w_a_bin} :
                                  {1'b0, w_a_bin - w_b_bin};

  calc_bin2bcd #(.CONV_ITER(CONV_ITER)) u_bin2bcd (
    .clk   (clk),
    .rst   (w_sub_rst),
    .start (r_conv_start),
    .bin   (w_mag),
    .done  (w_done),
    .hund  (w_bcd_hund),
    .tens  (w_bcd_tens),
    .ones  (w_bcd_ones)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_A;
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_held       <= 1'b0;
      r_held_code  <= 8'd0;
      r_a_tens     <= 4'd0;
      r_a_ones     <= 4'd0;
      r_b_tens     <= 4'd0;
      r_b_ones     <= 4'd0;
      r_a_cnt      <= '0;
      r_b_cnt      <= '0;
      r_op_minus   <= 1'b0;
      r_res_hund   <= 4'd0;
      r_res_tens   <= 4'd0;
      r_res_ones   <= 4'd0;
      r_res_neg    <= 1'b0;
      r_res_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_key_err    <= 1'b0;
      r_conv_start <= 1'b0;
    end else begin
      r_key_err    <= 1'b0;
      r_conv_start <= 1'b0;

      if (code_valid) begin
        if (code_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (code_byte == SC_BRK) begin
          r_brk <= 1'b1;
        end else if (r_brk) begin
          if (code_byte == r_held_code)
            r_held <= 1'b0;
          r_brk <= 1'b0;
          r_ext <= 1'b0;
        end else if (r_ext) begin
          r_ext <= 1'b0;
        end else if (!r_held) begin
          r_held      <= 1'b1;
          r_held_code <= code_byte;
        end
      end

      if (w_clear) begin
        r_state     <= S_A;
        r_a_tens    <= 4'd0;
        r_a_ones    <= w_dig.val;
        r_a_cnt     <= CNT_W'(w_dig.vld);
        r_b_tens    <= 4'd0;
        r_b_ones    <= 4'd0;
        r_b_cnt     <= '0;
        r_op_minus  <= 1'b0;
        r_res_hund  <= 4'd0;
        r_res_tens  <= 4'd0;
        r_res_ones  <= 4'd0;
        r_res_neg   <= 1'b0;
        r_res_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_A: if (w_press) begin
            if (w_dig.vld) begin
              if (r_a_cnt < MAXD) begin
                r_a_tens <= r_a_ones;
                r_a_ones <= w_dig.val;
                r_a_cnt  <= r_a_cnt + 1'b1;
              end else begin
                r_key_err <= 1'b1;
              end
            end else if (w_op) begin
              if (r_a_cnt != '0) begin
                r_op_minus <= w_minus;
                r_state    <= S_B;
              end else begin
                r_key_err <= 1'b1;
              end
            end else if (w_eq) begin
              r_key_err <= 1'b1;
            end
          end
          S_B: if (w_press) begin
            if (w_dig.vld) begin
              if (r_b_cnt < MAXD) begin
                r_b_tens <= r_b_ones;
                r_b_ones <= w_dig.val;
                r_b_cnt  <= r_b_cnt + 1'b1;
              end else begin
                r_key_err <= 1'b1;
              end
            end else if (w_op) begin
              if (r_b_cnt == '0)
                r_op_minus <= w_minus;
              else
                r_key_err <= 1'b1;
            end else if (w_eq) begin
              r_state      <= S_CONV;
              r_busy       <= 1'b1;
              r_conv_start <= 1'b1;
            end
          end
          S_CONV: begin
            // Sign is taken in the entry cycle, alongside loading the converter.
            if (r_conv_start)
              r_res_neg <= r_op_minus && w_a_lt_b;
            if (w_press && (w_dig.vld || w_op || w_eq))
              r_key_err <= 1'b1;
            if (w_done) begin
              r_res_hund  <= w_bcd_hund;
              r_res_tens  <= w_bcd_tens;
              r_res_ones  <= w_bcd_ones;
              r_res_valid <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_SHOW;
            end
          end
          S_SHOW: if (w_press && w_op) begin
            r_key_err <= 1'b1;
          end
          default: r_state <= S_A;
        endcase
      end
    end
  end

  assign a_tens   = r_a_tens;
  assign a_ones   = r_a_ones;
  assign b_tens   = r_b_tens;
  assign b_ones   = r_b_ones;
  assign op_minus = r_op_minus;
  assign r_hund   = r_res_hund;
  assign r_tens   = r_res_tens;
  assign r_ones   = r_res_ones;
  assign r_neg    = r_res_neg;
  assign r_valid  = r_res_valid;
  assign busy     = r_busy;
  assign key_err  = r_key_err;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer: table of scan-code sequences with expected
// displays, hand-written corner sequences, and a random key stream checked
// against a value-level calculator model.
module tb_calc_key_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code_byte = 8'd0;
  logic [3:0] a_tens, a_ones, b_tens, b_ones, r_hund, r_tens, r_ones;
  logic       op_minus, r_neg, r_valid, busy, key_err;

  calc_key_sequencer dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code_byte(code_byte),
    .a_tens(a_tens), .a_ones(a_ones), .b_tens(b_tens), .b_ones(b_ones),
    .op_minus(op_minus), .r_hund(r_hund), .r_tens(r_tens), .r_ones(r_ones),
    .r_neg(r_neg), .r_valid(r_valid), .busy(busy), .key_err(key_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int at, input int ao, input int bt,
                           input int bo, input int op, input int rh, input int rt,
                           input int ro, input int ng, input int vl);
    check({tag, ".a_tens"},   int'(a_tens),   at);
    check({tag, ".a_ones"},   int'(a_ones),   ao);
    check({tag, ".b_tens"},   int'(b_tens),   bt);
    check({tag, ".b_ones"},   int'(b_ones),   bo);
    check({tag, ".op_minus"}, int'(op_minus), op);
    check({tag, ".r_hund"},   int'(r_hund),   rh);
    check({tag, ".r_tens"},   int'(r_tens),   rt);
    check({tag, ".r_ones"},   int'(r_ones),   ro);
    check({tag, ".r_neg"},    int'(r_neg),    ng);
    check({tag, ".r_valid"},  int'(r_valid),  vl);
  endtask

  // One scan byte per clock; outputs are sampled 1ns after the edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code_valid = 1'b1;
    code_byte  = b;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  // Called 1ns after the '=' edge; returns cycles until r_valid rises.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (r_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // ---------------- behavioural model (values, not registers) -------------
  localparam int M_A = 0, M_B = 1, M_CONV = 2, M_SHOW = 3;
  int dig_code[10] = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D};
  int m_ext, m_brk, m_held, m_hcode, m_mode;
  int m_a, m_acnt, m_b, m_bcnt, m_minus, m_res, m_valid;

  function automatic int dig_of(input int code);
    for (int i = 0; i < 10; i++)
      if (dig_code[i] == code) return i;
    return -1;
  endfunction

  task automatic m_clear();
    m_a = 0; m_acnt = 0; m_b = 0; m_bcnt = 0;
    m_minus = 0; m_res = 0; m_valid = 0; m_mode = M_A;
  endtask

  task automatic m_reset();
    m_clear();
    m_ext = 0; m_brk = 0; m_held = 0; m_hcode = 0;
  endtask

  task automatic m_key(input int code, output int err, output int go);
    int d;
    bit isop, iseq;
    d = dig_of(code);
    isop = (code == 'h79) || (code == 'h7B);
    iseq = (code == 'h55);
    err = 0;
    go = 0;
    if (code == 'h76) begin
      m_clear();
    end else if (m_mode == M_A) begin
      if (d >= 0) begin
        if (m_acnt < 2) begin m_a = (m_a % 10) * 10 + d; m_acnt++; end
        else err = 1;
      end else if (isop) begin
        if (m_acnt > 0) begin m_minus = (code == 'h7B); m_mode = M_B; end
        else err = 1;
      end else if (iseq) err = 1;
    end else if (m_mode == M_B) begin
      if (d >= 0) begin
        if (m_bcnt < 2) begin m_b = (m_b % 10) * 10 + d; m_bcnt++; end
        else err = 1;
      end else if (isop) begin
        if (m_bcnt == 0) m_minus = (code == 'h7B);
        else err = 1;
      end else if (iseq) begin
        m_res  = m_minus ? m_a - m_b : m_a + m_b;
        m_mode = M_CONV;
        go     = 1;
      end
    end else if (m_mode == M_CONV) begin
      if (d >= 0 || isop || iseq) err = 1;
    end else begin
      if (d >= 0) begin
        m_clear();
        m_a = d;
        m_acnt = 1;
      end else if (isop) err = 1;
    end
  endtask

  task automatic m_byte(input int code, output int err, output int go);
    err = 0;
    go = 0;
    if (code == 'hE0) m_ext = 1;
    else if (code == 'hF0) m_brk = 1;
    else if (m_brk) begin
      if (code == m_hcode) m_held = 0;
      m_brk = 0;
      m_ext = 0;
    end else if (m_ext) m_ext = 0;
    else if (!m_held) begin
      m_held = 1;
      m_hcode = code;
      m_key(code, err, go);
    end
  endtask

  task automatic m_expect(input string tag);
    int mag;
    mag = (m_res < 0) ? -m_res : m_res;
    check_all(tag, m_a / 10, m_a % 10, m_b / 10, m_b % 10, m_minus,
              m_valid ? mag / 100 : 0, m_valid ? (mag / 10) % 10 : 0,
              m_valid ? mag % 10 : 0,
              (m_mode >= M_CONV && m_res < 0) ? 1 : 0, m_valid);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    code_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_reset();
  endtask

  task automatic rsend(input int code);
    int err, go, lat;
    send(8'(code));
    m_byte(code, err, go);
    check("rnd.key_err", int'(key_err), err);
    if (go) begin
      check("rnd.busy", int'(busy), 1);
      wait_valid(lat);
      check("rnd.latency", lat, 10);
      m_mode = M_SHOW;
      m_valid = 1;
    end
    m_expect("rnd");
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    string name;
    string seq;
    int at, ao, bt, bo, op, rh, rt, ro, ng, vl, errs;
  } vec_t;

  vec_t tv[10];

  task automatic run_vec(input vec_t v);
    string tok;
    logic [7:0] b;
    int errs, lat;
    do_reset();
    errs = 0;
    for (int i = 0; i < v.seq.len(); i += 3) begin
      tok = v.seq.substr(i, i + 1);
      b = 8'(tok.atohex());
      send(b);
      errs += int'(key_err);
      if (busy) begin
        wait_valid(lat);
        check({v.name, ".latency"}, lat, 10);
      end
    end
    check_all(v.name, v.at, v.ao, v.bt, v.bo, v.op, v.rh, v.rt, v.ro, v.ng, v.vl);
    check({v.name, ".key_errs"}, errs, v.errs);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    tv[0] = '{"plan1", "7D F0 7D 7D F0 7D 79 F0 79 70 F0 70 55 F0 55", 9,9,0,0,0, 0,9,9,0,1, 0};
    tv[1] = '{"sub_neg", "7A F0 7A 7B F0 7B 6C F0 6C 55 F0 55", 0,3,0,7,1, 0,0,4,1,1, 0};
    tv[2] = '{"max", "7D F0 7D 7D F0 7D 79 F0 79 7D F0 7D 7D F0 7D 55 F0 55", 9,9,9,9,0, 1,9,8,0,1, 0};
    tv[3] = '{"typematic", "7D 7D 7D F0 7D", 0,9,0,0,0, 0,0,0,0,0, 0};
    tv[4] = '{"op_repl", "69 F0 69 79 F0 79 7B F0 7B 72 F0 72 55 F0 55", 0,1,0,2,1, 0,0,1,1,1, 0};
    tv[5] = '{"empty_b", "74 F0 74 79 F0 79 55 F0 55", 0,6,0,0,0, 0,0,6,0,1, 0};
    tv[6] = '{"early_keys", "55 F0 55 79 F0 79 5A F0 5A", 0,0,0,0,0, 0,0,0,0,0, 2};
    tv[7] = '{"show_digit", "69 F0 69 79 F0 79 69 F0 69 55 F0 55 74 F0 74", 0,6,0,0,0, 0,0,0,0,0, 0};
    tv[8] = '{"show_op", "73 F0 73 7B F0 7B 73 F0 73 55 F0 55 79 F0 79 55 F0 55", 0,5,0,5,1, 0,0,0,0,1, 1};
    tv[9] = '{"b_over", "72 F0 72 7B F0 7B 72 F0 72 73 F0 73 74 F0 74 7B F0 7B 55 F0 55", 0,2,2,5,1, 0,2,3,1,1, 2};

    do_reset();
    check_all("reset", 0,0,0,0,0, 0,0,0,0,0);
    check("reset.busy", int'(busy), 0);
    check("reset.key_err", int'(key_err), 0);

    for (int i = 0; i < 10; i++) run_vec(tv[i]);

    // Third digit rejected, then extended key make/break changes nothing.
    do_reset();
    send(8'h69); send(8'hF0); send(8'h69);
    send(8'h72); send(8'hF0); send(8'h72);
    send(8'h73);
    check("third.key_err", int'(key_err), 1);
    check("third.a_tens", int'(a_tens), 1);
    check("third.a_ones", int'(a_ones), 2);
    @(posedge clk); #1;
    check("third.err_pulse", int'(key_err), 0);
    send(8'hF0); send(8'h73);
    send(8'hE0); send(8'h5A); send(8'hF0); send(8'hE0); send(8'h5A);
    check("ext.key_err", int'(key_err), 0);
    check_all("ext", 1,2,0,0,0, 0,0,0,0,0);
    send(8'h79); send(8'hF0); send(8'h79); send(8'h6B);
    check("ext.still_a.b_ones", int'(b_ones), 4);

    // Keys during conversion are refused; ESC aborts it.
    do_reset();
    send(8'h72); send(8'hF0); send(8'h72);
    send(8'h79); send(8'hF0); send(8'h79);
    send(8'h73); send(8'hF0); send(8'h73);
    send(8'h55);
    check("abort.busy_on", int'(busy), 1);
    send(8'hF0); send(8'h55);
    send(8'h70);
    check("abort.busy_key_err", int'(key_err), 1);
    send(8'hF0); send(8'h70);
    check("abort.still_busy", int'(busy), 1);
    send(8'h76);
    check("abort.busy_off", int'(busy), 0);
    check_all("abort", 0,0,0,0,0, 0,0,0,0,0);
    repeat (12) @(posedge clk);
    #1;
    check("abort.no_late_valid", int'(r_valid), 0);
    check("abort.no_late_ones", int'(r_ones), 0);

    // Reset mid-entry, coincident with a code strobe.
    do_reset();
    send(8'h69); send(8'hF0); send(8'h69);
    send(8'h79); send(8'hF0); send(8'h79);
    send(8'h72);
    @(negedge clk);
    reset = 1'b1;
    code_valid = 1'b1;
    code_byte = 8'h73;
    @(posedge clk);
    #1;
    reset = 1'b0;
    code_valid = 1'b0;
    check_all("midreset", 0,0,0,0,0, 0,0,0,0,0);
    check("midreset.key_err", int'(key_err), 0);
    send(8'h69);
    check("midreset.held_clear.a_ones", int'(a_ones), 1);

    // Random key stream against the model.
    do_reset();
    for (int ev = 0; ev < 250; ev++) begin
      int r, code, ext;
      r = int'($urandom_range(0, 99));
      ext = 0;
      if (r < 50)      code = dig_code[$urandom_range(0, 9)];
      else if (r < 64) code = ($urandom_range(0, 1) != 0) ? 'h79 : 'h7B;
      else if (r < 76) code = 'h55;
      else if (r < 80) code = 'h76;
      else if (r < 88) code = 'h5A;
      else begin
        ext = 1;
        code = dig_code[$urandom_range(0, 9)];
      end
      if (ext != 0) rsend('hE0);
      rsend(code);
      if ($urandom_range(0, 4) == 0) begin
        if (ext != 0) rsend('hE0);
        rsend(code);
      end
      if (ext != 0) rsend('hE0);
      rsend('hF0);
      rsend(code);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
